// File: rtl/exec_stage.sv
// Single-issue execute stage: 1-cycle ALU with a registered write-back slot.
// Define EXEC_STAGE_MUL_EN to add the iterative shift-add multiplier (op 11).
module exec_stage #(
  parameter int MUL_CYCLES = 32
) (
  input  logic        i_clk,
  input  logic        i_rstn,
  input  logic        i_valid,
  output logic        o_ready,
  input  logic [3:0]  i_op,
  input  logic [31:0] i_rs1_data,
  input  logic [31:0] i_rs2_data,
  input  logic [31:0] i_imm,
  input  logic        i_use_imm,
  input  logic [5:0]  i_rd,
  output logic        o_wb_valid,
  input  logic        i_wb_ready,
  output logic [63:0] o_wb_reg,
  output logic [0:0]  o_state
);

  // Handshakes: a transfer happens on a rising edge where valid && ready are
  // both high; the producer holds its payload stable until that edge.

  localparam logic [0:0] IDLE = 1'b0;

  logic [0:0]  state;
  logic [31:0] operand_b;
  logic [31:0] alu_res;
  logic        accept;
  logic        mul_start;
  logic        mul_done;
  logic [31:0] mul_res;
  logic [5:0]  mul_rd;
  logic        wb_valid;
  logic [63:0] wb_reg;

  function automatic logic [63:0] pack_wb(input logic [5:0] rd, input logic [31:0] res);
    return {26'd0, rd, (rd == 6'd0) ? 32'd0 : res};
  endfunction

  assign operand_b = i_use_imm ? i_imm : i_rs2_data;
  assign o_ready   = (state == IDLE) && (!wb_valid || i_wb_ready);
  assign accept    = i_valid && o_ready;

  always_comb begin
    alu_res = 32'd0;
    case (i_op)
      4'd0:    alu_res = i_rs1_data + operand_b;
      4'd1:    alu_res = i_rs1_data - operand_b;
      4'd2:    alu_res = i_rs1_data & operand_b;
      4'd3:    alu_res = i_rs1_data | operand_b;
      4'd4:    alu_res = i_rs1_data ^ operand_b;
      4'd5:    alu_res = i_rs1_data << operand_b[4:0];
      4'd6:    alu_res = i_rs1_data >> operand_b[4:0];
      4'd7:    alu_res = $unsigned($signed(i_rs1_data) >>> operand_b[4:0]);
      4'd8:    alu_res = ($signed(i_rs1_data) < $signed(operand_b)) ? 32'd1 : 32'd0;
      4'd9:    alu_res = (i_rs1_data < operand_b) ? 32'd1 : 32'd0;
      4'd10:   alu_res = operand_b;
      default: alu_res = 32'd0;
    endcase
  end

`ifdef EXEC_STAGE_MUL_EN
  localparam logic [0:0] BUSY = 1'b1;
  // Bits of B consumed per cycle so that all 32 are covered in MUL_CYCLES cycles.
  localparam int STEP = (32 + MUL_CYCLES - 1) / MUL_CYCLES;

  logic [31:0] mul_a;
  logic [31:0] mul_b;
  logic [31:0] mul_acc;
  logic [31:0] acc_next;
  logic [5:0]  mul_cnt;

  always_comb begin
    acc_next = mul_acc;
    for (int i = 0; i < STEP; i++) begin
      if (mul_b[i]) acc_next = acc_next + (mul_a << i);
    end
  end

  assign mul_start = accept && (i_op == 4'd11);
  assign mul_done  = (state == BUSY) && (mul_cnt == 6'd0);
  assign mul_res   = acc_next;

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state   <= IDLE;
      mul_a   <= 32'd0;
      mul_b   <= 32'd0;
      mul_acc <= 32'd0;
      mul_cnt <= 6'd0;
      mul_rd  <= 6'd0;
    end else begin
      case (state)
        IDLE: begin
          if (mul_start) begin
            state   <= BUSY;
            mul_a   <= i_rs1_data;
            mul_b   <= operand_b;
            mul_acc <= 32'd0;
            mul_cnt <= 6'(MUL_CYCLES - 1);
            mul_rd  <= i_rd;
          end
        end
        default: begin
          mul_acc <= acc_next;
          mul_a   <= mul_a << STEP;
          mul_b   <= mul_b >> STEP;
          if (mul_cnt == 6'd0) state <= IDLE;
          else                 mul_cnt <= mul_cnt - 6'd1;
        end
      endcase
    end
  end
`else
  assign state     = IDLE;
  assign mul_start = 1'b0;
  assign mul_done  = 1'b0;
  assign mul_res   = 32'd0;
  assign mul_rd    = 6'd0;
`endif

  // A MUL can only start with the slot empty or draining, so mul_done never
  // collides with a held result.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      wb_valid <= 1'b0;
      wb_reg   <= 64'd0;
    end else if (accept && !mul_start) begin
      wb_valid <= 1'b1;
      wb_reg   <= pack_wb(i_rd, alu_res);
    end else if (mul_done) begin
      wb_valid <= 1'b1;
      wb_reg   <= pack_wb(mul_rd, mul_res);
    end else if (i_wb_ready) begin
      wb_valid <= 1'b0;
    end
  end

  assign o_wb_valid = wb_valid;
  assign o_wb_reg   = wb_reg;
  assign o_state    = state;

endmodule

// File: doc/exec_stage.md
EXEC_STAGE -- requirements
Module: exec_stage

Interface
REQ-001 SHALL have parameter MUL_CYCLES, default 32, meaning iterative multiply length in cycles (legal values 1..32).
REQ-002 SHALL have port i_clk, input, 1, rising-edge clock.
REQ-003 SHALL have port i_rstn, input, 1, reset, asynchronous, active-low.
REQ-004 SHALL have port i_valid, input, 1, decode presents an operation.
REQ-005 SHALL have port o_ready, output, 1, stage accepts the operation this cycle.
REQ-006 SHALL have port i_op, input, 4, opcode: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SLL, 6 SRL, 7 SRA, 8 SLT, 9 SLTU, 10 PASSB, 11 MUL, 12-15 reserved.
REQ-007 SHALL have port i_rs1_data, input, 32, operand A.
REQ-008 SHALL have port i_rs2_data, input, 32, register operand B.
REQ-009 SHALL have port i_imm, input, 32, immediate operand.
REQ-010 SHALL have port i_use_imm, input, 1, when 1, operand B = i_imm, else i_rs2_data.
REQ-011 SHALL have port i_rd, input, 6, destination register address.
REQ-012 SHALL have port o_wb_valid, output, 1, o_wb_reg holds a result.
REQ-013 SHALL have port i_wb_ready, input, 1, write-back consumes o_wb_reg this cycle.
REQ-014 SHALL have port o_wb_reg, output, 64, packet {26'd0, rd[5:0], result[31:0]}.

Function
REQ-015 Transfer in SHALL occur on a rising edge where i_valid && o_ready; transfer out SHALL occur where o_wb_valid && i_wb_ready.
REQ-016 States SHALL be IDLE and BUSY; o_ready SHALL be (state==IDLE) && (!o_wb_valid || i_wb_ready), combinational.
REQ-017 Non-MUL op accepted at edge N: o_wb_reg and o_wb_valid=1 SHALL be visible after edge N, i.e. 1-cycle latency; state stays IDLE.
REQ-018 With back-to-back accepts and i_wb_ready=1, the stage SHALL sustain one result per cycle.
REQ-019 o_wb_valid and o_wb_reg SHALL hold stable while o_wb_valid && !i_wb_ready.
REQ-020 o_wb_valid SHALL clear after a transfer out, unless a new result is loaded on the same edge.
REQ-021 Arithmetic SHALL be 32-bit modulo 2^32; carry and overflow SHALL be discarded.
REQ-022 Shifts SHALL use B[4:0] only; SRA SHALL be arithmetic.
REQ-023 SLT and SLTU SHALL produce 32'd1 or 32'd0 (signed and unsigned compare respectively).
REQ-024 PASSB SHALL produce B.
REQ-025 Reserved ops SHALL produce result 0, with normal latency and write-back.
REQ-026 When rd==0, the result field SHALL be forced to 32'd0.
REQ-027 MUL (when compiled in) accepted at edge N: the stage SHALL enter BUSY, run shift-add for MUL_CYCLES cycles, then load the low 32 bits of A*B.
REQ-028 For MUL, o_wb_valid SHALL be visible after edge N+MUL_CYCLES, and the stage SHALL return to IDLE on that edge.
REQ-029 o_ready SHALL be 0 throughout BUSY; i_valid SHALL be ignored in BUSY.
REQ-030 A pending unconsumed result SHALL block MUL acceptance via REQ-016, so a completing MUL never overwrites a held result.

Reset
REQ-031 While i_rstn=0: state=IDLE, o_wb_valid=0, o_wb_reg=64'd0, multiplier accumulator and counter SHALL be 0.
REQ-032 Reset asserted mid-MUL SHALL abort the operation; no result SHALL be produced after release.
REQ-033 o_ready SHALL be 1 in the first cycle after reset release.

Configuration
REQ-034 Macro EXEC_STAGE_MUL_EN defined: op 11 SHALL behave as REQ-027..030.
REQ-035 Macro EXEC_STAGE_MUL_EN undefined: op 11 SHALL be reserved per REQ-025; BUSY and the multiplier datapath SHALL be absent.

Verification
REQ-036 ADD: A=0xFFFFFFFF, B=1, rd=5 -> after 1 edge, o_wb_valid=1, o_wb_reg=0x00000005_00000000.
REQ-037 SRA and SLT: A=0x80000000, imm=4, use_imm=1, SRA -> result 0xF8000000; SLT with A=-1, B=1 -> 1; SLTU with same operands -> 0.
REQ-038 Stall: i_wb_ready=0 for 3 cycles after a result -> o_ready=0, o_wb_reg stable; on i_wb_ready=1, a new op is accepted on the same edge.
REQ-039 MUL (EXEC_STAGE_MUL_EN, MUL_CYCLES=32): A=7, B=6, rd=3 -> o_ready=0 for 32 cycles, then o_wb_reg=0x00000003_0000002A; A=B=0x10000 -> result 0.
REQ-040 Reset mid-MUL at cycle 10 -> o_wb_valid=0 and o_wb_reg=0 immediately; o_wb_valid stays 0 until a new accept.
REQ-041 rd=0 with ADD 3+4 -> o_wb_reg=64'd0 with o_wb_valid=1; reserved op 13 -> result 0.
